main_memory_ctrl: RTL and testbench

MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

---
 rtl/main_memory_ctrl_pkg.sv | 13 +
 rtl/main_memory_ctrl_line_ram.sv | 24 ++
 rtl/main_memory_ctrl.sv | 92 +++++++++
 tb/tb_main_memory_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/main_memory_ctrl_pkg.sv
// Shared types and sizes for the main memory controller.
// Line geometry and the request FSM state encoding.
package main_memory_ctrl_pkg;
  localparam int LINE_BITS   = 256;
  localparam int INDEX_BITS  = 9;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;
endpackage

// File: rtl/main_memory_ctrl_line_ram.sv
// Single-port synchronous line array with write enable.
// Contents are intentionally not reset.
module line_ram
  import main_memory_ctrl_pkg::*;
#(
  parameter int W  = LINE_BITS,
  parameter int AW = INDEX_BITS
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [2**AW];
  logic [W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency line memory behind a one-outstanding request FSM.
// Reads sample the array on entry to ACK; writes commit leaving ACK.
module main_memory_ctrl
  import main_memory_ctrl_pkg::*;
#(
  parameter int LATENCY = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_enable_i,
  input  logic                 mem_write_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [LINE_BITS-1:0] mem_data_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_ack_o,
  output logic                 busy_o
);
  state_t                r_state;
  logic [7:0]            r_cnt;
  logic [INDEX_BITS-1:0] r_idx;
  logic                  r_write;
  logic [LINE_BITS-1:0]  r_wdata;
  logic [LINE_BITS-1:0]  r_data;
  logic                  r_ack;
  logic                  r_busy;

  logic [INDEX_BITS-1:0] w_idx;
  logic                  w_we;
  logic [LINE_BITS-1:0]  w_rdata;

  // In IDLE the RAM already reads the incoming line so LATENCY=1 works
  assign w_idx = (r_state == S_IDLE)
               ? mem_addr_i[OFFSET_BITS +: INDEX_BITS]
               : r_idx;
  assign w_we  = (r_state == S_ACK) && r_write;

  line_ram #(
    .W  (LINE_BITS),
    .AW (INDEX_BITS)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (mem_enable_i) begin
            r_idx   <= mem_addr_i[OFFSET_BITS +: INDEX_BITS];
            r_write <= mem_write_i;
            r_wdata <= mem_data_i;
            r_cnt   <= 8'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            if (!r_write) r_data <= w_rdata;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_data_o = r_data;
  assign mem_ack_o  = r_ack;
  assign busy_o     = r_busy;
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl: vector table plus
// hand-written held-enable, reset-abort and LATENCY=1 sequences.
module tb_main_memory_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] din = '0, dout;
  logic         ack, busy;

  logic         en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] din1 = '0, dout1;
  logic         ack1, busy1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  main_memory_ctrl #(.LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en), .mem_write_i(wr),
    .mem_addr_i(addr), .mem_data_i(din), .mem_data_o(dout),
    .mem_ack_o(ack), .busy_o(busy)
  );

  main_memory_ctrl #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en1), .mem_write_i(wr1),
    .mem_addr_i(addr1), .mem_data_i(din1), .mem_data_o(dout1),
    .mem_ack_o(ack1), .busy_o(busy1)
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp;
  } vec_t;

  vec_t vt[8];

  localparam logic [255:0] DB = {8{32'hDEADBEEF}};
  localparam logic [255:0] PA = {8{32'hA5A50001}};
  localparam logic [255:0] PB = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] PC = {8{32'h13579BDF}};
  localparam logic [255:0] D1 = {8{32'h11112222}};
  localparam logic [255:0] D2 = {8{32'hBAD0BAD0}};
  localparam logic [255:0] PE = {8{32'hFEEDF00D}};
  localparam logic [255:0] PF = {8{32'h0F0F5A5A}};

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One request on the LATENCY=10 instance, fully checked
  task automatic xact(input string nm, input logic w,
                      input logic [31:0] a, input logic [255:0] d,
                      input logic [255:0] exp);
    int lat;
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; din = d;
    @(negedge clk);
    en = 1'b0;
    lat = 1;
    chk({nm, " busy"}, 256'(busy), 256'(1));
    while (!ack && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " lat"}, 256'(lat), 256'(11));
    chk({nm, " data"}, dout, exp);
    @(negedge clk);
    chk({nm, " ack1"}, 256'(ack), 256'(0));
    chk({nm, " idle"}, 256'(busy), 256'(0));
  endtask

  initial begin
    int nack;
    int pos[4];
    int bc, ap;
    logic [255:0] rdv;

    vt[0] = '{1'b1, 32'h0000_0000, PB, '0};
    vt[1] = '{1'b1, 32'h0000_0040, DB, '0};
    vt[2] = '{1'b0, 32'h0000_0055, '0, DB};
    vt[3] = '{1'b1, 32'h0000_3FE0, PA, DB};
    vt[4] = '{1'b0, 32'hFFFF_FFE0, '0, PA};
    vt[5] = '{1'b0, 32'h0000_001F, '0, PB};
    vt[6] = '{1'b1, 32'h0000_7FE0, PC, PB};
    vt[7] = '{1'b0, 32'h0000_3FE0, '0, PC};

    repeat (2) @(negedge clk);
    chk("rst ack", 256'(ack), 256'(0));
    chk("rst busy", 256'(busy), 256'(0));
    chk("rst data", dout, '0);
    chk("rst ack1", 256'(ack1), 256'(0));
    chk("rst busy1", 256'(busy1), 256'(0));
    rst = 1'b1;

    for (int i = 0; i < 8; i++)
      xact($sformatf("vec%0d", i), vt[i].wr, vt[i].addr,
           vt[i].data, vt[i].exp);

    // Address/data changed while the write is in WAIT
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h20; din = D1;
    @(negedge clk);
    en = 1'b0; addr = 32'h40; din = D2;
    for (int i = 0; i < 40 && !ack; i++) @(negedge clk);
    chk("ign ack", 256'(ack), 256'(1));
    @(negedge clk);
    xact("ign rd20", 1'b0, 32'h20, '0, D1);
    xact("ign rd40", 1'b0, 32'h40, '0, DB);

    // Held enable for 40 cycles
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 32'h55;
    nack = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack) begin
        if (nack < 4) pos[nack] = k;
        nack++;
      end
    end
    en = 1'b0;
    chk("held n", 256'(nack), 256'(3));
    chk("held 1st", 256'(pos[0]), 256'(11));
    chk("held gap1", 256'(pos[1] - pos[0]), 256'(12));
    chk("held gap2", 256'(pos[2] - pos[1]), 256'(12));
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("held drain", 256'(busy), 256'(0));

    // Reset three cycles into a write of line 2
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h40; din = PE;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid busy0", 256'(busy), 256'(1));
    rst = 1'b0;
    #1;
    chk("mid ack", 256'(ack), 256'(0));
    chk("mid busy", 256'(busy), 256'(0));
    chk("mid data", dout, '0);
    @(negedge clk);
    chk("mid hold", {dout[254:0], ack}, '0);
    rst = 1'b1;
    nack = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ack) nack++;
    end
    chk("mid noack", 256'(nack), 256'(0));
    xact("mid rd40", 1'b0, 32'h40, '0, DB);

    // LATENCY=1 instance
    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h60; din1 = PF;
    @(negedge clk);
    en1 = 1'b0;
    bc = 0; ap = 0;
    for (int k = 1; k <= 5; k++) begin
      if (busy1) bc++;
      if (ack1) ap = k;
      @(negedge clk);
    end
    chk("l1w busy", 256'(bc), 256'(2));
    chk("l1w ackpos", 256'(ap), 256'(2));
    chk("l1w data", dout1, '0);

    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h7F;
    @(negedge clk);
    en1 = 1'b0;
    bc = 0; ap = 0; rdv = '0;
    for (int k = 1; k <= 5; k++) begin
      if (busy1) bc++;
      if (ack1) begin
        ap = k;
        rdv = dout1;
      end
      @(negedge clk);
    end
    chk("l1r busy", 256'(bc), 256'(2));
    chk("l1r ackpos", 256'(ap), 256'(2));
    chk("l1r data", rdv, PF);
    chk("l1r hold", dout1, PF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
